sum_tree_trig: RTL and testbench

- Parametrised successor of the 16-input fixed summer.
- Performs signed pipelined summation of NCH channel samples with a per-channel mask, full-precision internal growth and saturating output.
- Adds valid tracking and a threshold trigger with hold-off.
- Sits after the per-channel baseline subtraction and feeds the master-trigger sum path.

---
 rtl/sum_tree_trig.sv | 161 ++++++++++++++++
 tb/tb_sum_tree_trig.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_tree_trig.sv
// Signed pipelined adder tree over NCH masked channels with saturating output,
// valid tracking and a re-crossing threshold trigger with hold-off.
module sum_tree_trig #(
    parameter int NCH = 16,
    parameter int DW  = 16,
    parameter int OW  = 16,
    parameter int HW  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH*DW-1:0]   din,
    input  logic                din_valid,
    input  logic [NCH-1:0]      mask,
    input  logic [OW-1:0]       thr,
    input  logic [HW-1:0]       holdoff,
    output logic [OW-1:0]       sum,
    output logic                sum_valid,
    output logic                sat,
    output logic                trig
);

    localparam int L  = $clog2(NCH);
    localparam int SW = DW + L;

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic {
        ARMED = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Every tree level is held at the final width; upper bits are plain sign
    // extension, so no level can wrap and unused upper bits trim away.
    logic signed [SW-1:0] tree_r [L+1][NCH];
    logic        [L:0]    vld_r;
    logic signed [SW-1:0] ext_s  [NCH];

    logic signed [SW-1:0] full_s;
    logic signed [SW-1:0] thr_ext_s;
    logic                 fin_valid_s;
    logic                 ge_s;
    logic        [OW-1:0] sum_nxt_s;
    logic                 sat_nxt_s;

    state_t               state_r;
    state_t               state_nxt_s;
    logic        [HW-1:0] cnt_r;
    logic        [HW-1:0] cnt_nxt_s;
    logic        [HW-1:0] cnt_dec_s;
    logic                 trig_nxt_s;

    // Sign-extend each raw channel sample to the full tree width.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ext_s[i] = SW'($signed(din[DW*i +: DW]));
        end
    end

    // Stage 0 masking plus the adder-tree levels and the valid shift line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int lv = 0; lv <= L; lv++) begin
                for (int j = 0; j < NCH; j++) begin
                    tree_r[lv][j] <= {SW{1'b0}};
                end
            end
            vld_r <= {(L+1){1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                tree_r[0][i] <= mask[i] ? ext_s[i] : {SW{1'b0}};
            end
            for (int lv = 1; lv <= L; lv++) begin
                for (int j = 0; j < NCH/2; j++) begin
                    if (j < (NCH >> lv)) begin
                        tree_r[lv][j] <= tree_r[lv-1][2*j] + tree_r[lv-1][2*j+1];
                    end else begin
                        tree_r[lv][j] <= {SW{1'b0}};
                    end
                end
                for (int j = NCH/2; j < NCH; j++) begin
                    tree_r[lv][j] <= {SW{1'b0}};
                end
            end
            vld_r <= {vld_r[L-1:0], din_valid};
        end
    end

    assign full_s      = tree_r[L][0];
    assign fin_valid_s = vld_r[L];
    assign thr_ext_s   = SW'($signed(thr));
    assign ge_s        = (full_s >= thr_ext_s);
    assign cnt_dec_s   = (cnt_r == {HW{1'b0}}) ? {HW{1'b0}} : (cnt_r - {{(HW-1){1'b0}}, 1'b1});

    // Clip the full-precision sum into the OW-bit output range.
    always_comb begin
        sum_nxt_s = full_s[OW-1:0];
        sat_nxt_s = 1'b0;
        if (full_s > SAT_MAX) begin
            sum_nxt_s = SAT_MAX[OW-1:0];
            sat_nxt_s = 1'b1;
        end else if (full_s < SAT_MIN) begin
            sum_nxt_s = SAT_MIN[OW-1:0];
            sat_nxt_s = 1'b1;
        end else begin
            sum_nxt_s = full_s[OW-1:0];
            sat_nxt_s = 1'b0;
        end
    end

    // Trigger next-state: re-arm needs the hold-off to expire on this edge and a
    // valid sum below threshold, so a sustained level cannot retrigger.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        trig_nxt_s  = 1'b0;
        case (state_r)
            ARMED: begin
                if (fin_valid_s && ge_s) begin
                    state_nxt_s = HOLD;
                    cnt_nxt_s   = holdoff;
                    trig_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ARMED;
                end
            end
            HOLD: begin
                cnt_nxt_s = cnt_dec_s;
                if ((cnt_dec_s == {HW{1'b0}}) && fin_valid_s && !ge_s) begin
                    state_nxt_s = ARMED;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = ARMED;
                cnt_nxt_s   = {HW{1'b0}};
            end
        endcase
    end

    // Output and trigger state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum       <= {OW{1'b0}};
            sat       <= 1'b0;
            sum_valid <= 1'b0;
            trig      <= 1'b0;
            state_r   <= ARMED;
            cnt_r     <= {HW{1'b0}};
        end else begin
            sum       <= sum_nxt_s;
            sat       <= sat_nxt_s;
            sum_valid <= fin_valid_s;
            trig      <= trig_nxt_s;
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_sum_tree_trig.sv
// Self-checking bench for sum_tree_trig: vector table, ramp, trigger hold-off
// sequence and mid-flight reset, all checked through an expected-result queue.
module tb_sum_tree_trig;

    localparam int NCH = 16;
    localparam int DW  = 16;
    localparam int OW  = 16;
    localparam int HW  = 16;
    localparam int LAT = 6;

    logic              clk;
    logic              reset;
    logic [NCH*DW-1:0] din;
    logic              din_valid;
    logic [NCH-1:0]    mask;
    logic [OW-1:0]     thr;
    logic [HW-1:0]     holdoff;
    logic [OW-1:0]     sum;
    logic              sum_valid;
    logic              sat;
    logic              trig;

    sum_tree_trig #(.NCH(NCH), .DW(DW), .OW(OW), .HW(HW)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .mask      (mask),
        .thr       (thr),
        .holdoff   (holdoff),
        .sum       (sum),
        .sum_valid (sum_valid),
        .sat       (sat),
        .trig      (trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NCH*DW-1:0] d;
        logic [NCH-1:0]    m;
        logic [15:0]       es;
        logic              esat;
        logic              etrig;
    } vec_t;

    typedef struct {
        logic [15:0] es;
        logic        esat;
        logic        etrig;
        int          issue;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[10];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [NCH*DW-1:0] fill(input logic [DW-1:0] v);
        return {NCH{v}};
    endfunction

    function automatic logic [NCH*DW-1:0] two_ch(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                                                 input logic [DW-1:0] rest);
        logic [NCH*DW-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*DW +: DW] = (i == 0) ? v0 : ((i == 1) ? v1 : rest);
        return r;
    endfunction

    function automatic logic [NCH*DW-1:0] idx_ch();
        logic [NCH*DW-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*DW +: DW] = DW'(i);
        return r;
    endfunction

    function automatic logic [NCH*DW-1:0] alt_ch();
        logic [NCH*DW-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*DW +: DW] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
        return r;
    endfunction

    task automatic send(input logic [NCH*DW-1:0] d, input logic [NCH-1:0] m, input logic v,
                        input logic push_it, input logic [15:0] es, input logic esat, input logic etrig);
        exp_t e;
        din       = d;
        mask      = m;
        din_valid = v;
        if (v && push_it) begin
            e.es = es; e.esat = esat; e.etrig = etrig; e.issue = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        din_valid = 1'b0;
    endtask

    // One clock: sample outputs 1 time unit after the edge and score them.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sum_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sum", int'(sum), int'(e.es));
                chk("sat", int'(sat), int'(e.esat));
                chk("trig", int'(trig), int'(e.etrig));
                chk("latency", cyc - e.issue, LAT);
            end
        end else begin
            chk("trig_idle", int'(trig), 0);
        end
    endtask

    task automatic drain(input int n);
        idle();
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        reset = 1'b1; din = '0; din_valid = 1'b0; mask = '0;
        thr = 16'h7FFF; holdoff = 16'd0;

        tbl[0] = '{idx_ch(),                        16'hFFFF, 16'd120,  1'b0, 1'b0};
        tbl[1] = '{fill(16'h7FFF),                  16'hFFFF, 16'h7FFF, 1'b1, 1'b1};
        tbl[2] = '{fill(16'h8000),                  16'hFFFF, 16'h8000, 1'b1, 1'b0};
        tbl[3] = '{alt_ch(),                        16'hFFFF, 16'hFFF8, 1'b0, 1'b0};
        tbl[4] = '{two_ch(16'hFFFB, 16'd1000, 16'd1000), 16'h0001, 16'hFFFB, 1'b0, 1'b0};
        tbl[5] = '{two_ch(16'hFFFB, 16'd1000, 16'd1000), 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[6] = '{two_ch(16'h7FFF, 16'd0, 16'd0),  16'hFFFF, 16'h7FFF, 1'b0, 1'b1};
        tbl[7] = '{two_ch(16'h7FFF, 16'd1, 16'd0),  16'hFFFF, 16'h7FFF, 1'b1, 1'b0};
        tbl[8] = '{two_ch(16'h8000, 16'hFFFF, 16'd0), 16'hFFFF, 16'h8000, 1'b1, 1'b0};
        tbl[9] = '{two_ch(16'h8000, 16'd0, 16'd0),  16'hFFFF, 16'h8000, 1'b0, 1'b0};

        step();
        step();
        chk("rst_sum", int'(sum), 0);
        chk("rst_valid", int'(sum_valid), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_trig", int'(trig), 0);
        reset = 1'b0;
        step();

        // Vector table, applied back to back with thr at full scale and no hold-off.
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].d, tbl[i].m, 1'b1, 1'b1, tbl[i].es, tbl[i].esat, tbl[i].etrig);
            step();
        end
        drain(8);

        // Ramp of 20 consecutive sets, each channel = n.
        for (int n = 0; n < 20; n++) begin
            send(fill(DW'(n)), 16'hFFFF, 1'b1, 1'b1, 16'(16 * n), 1'b0, 1'b0);
            step();
        end
        drain(8);

        // Trigger with hold-off: 50,150,200,50,50,150 against thr=100, holdoff=3.
        thr = 16'd100;
        holdoff = 16'd3;
        send(two_ch(16'd50,  16'd0, 16'd0), 16'h0001, 1'b1, 1'b1, 16'd50,  1'b0, 1'b0); step();
        send(two_ch(16'd150, 16'd0, 16'd0), 16'h0001, 1'b1, 1'b1, 16'd150, 1'b0, 1'b1); step();
        send(two_ch(16'd200, 16'd0, 16'd0), 16'h0001, 1'b1, 1'b1, 16'd200, 1'b0, 1'b0); step();
        send(two_ch(16'd50,  16'd0, 16'd0), 16'h0001, 1'b1, 1'b1, 16'd50,  1'b0, 1'b0); step();
        send(two_ch(16'd50,  16'd0, 16'd0), 16'h0001, 1'b1, 1'b1, 16'd50,  1'b0, 1'b0); step();
        send(two_ch(16'd150, 16'd0, 16'd0), 16'h0001, 1'b1, 1'b1, 16'd150, 1'b0, 1'b1); step();
        drain(8);

        // FSM is in HOLD; three sets go in flight and are then killed by reset.
        holdoff = 16'd40;
        for (int k = 0; k < 3; k++) begin
            send(two_ch(16'd500, 16'd0, 16'd0), 16'h0001, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
            step();
        end
        idle();
        step();
        reset = 1'b1;
        #1;
        chk("midrst_valid", int'(sum_valid), 0);
        chk("midrst_trig", int'(trig), 0);
        step();
        chk("midrst_sum", int'(sum), 0);
        reset = 1'b0;
        drain(10);

        // Armed after reset: a sum exactly at threshold fires.
        send(two_ch(16'd100, 16'd0, 16'd0), 16'h0001, 1'b1, 1'b1, 16'd100, 1'b0, 1'b1);
        step();
        drain(8);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
